// File: rtl/joypad_pkg.sv
// Shared constants for the NES controller port responder: bus addresses,
// button bit positions and the open-bus mask for the data byte.
package joypad_pkg;

  localparam logic [15:0] ADDR_JOY1 = 16'h4016;
  localparam logic [15:0] ADDR_JOY2 = 16'h4017;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Bits 7:5 of a controller read float and return the last bus value.
  localparam logic [7:0] OPEN_BUS_MASK = 8'hE0;

endpackage

// File: rtl/joypad_shift_register.sv
// One controller pad: parallel load of the button states, serial shift-out
// (filling with 1s) and a saturating count of bits read since the last load.
module joypad_shift_register #(
  parameter int NUM_BUTTONS = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_load,
  input  logic                   i_shift,
  input  logic [NUM_BUTTONS-1:0] i_buttons,
  output logic                   o_bit,
  output logic [3:0]             o_count
);

  logic [NUM_BUTTONS-1:0] shift_q;
  logic [3:0]             count_q;

  // Load wins over shift; the count stops at NUM_BUTTONS once the pad is drained.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (i_load) begin
      shift_q <= i_buttons;
      count_q <= '0;
    end else if (i_shift) begin
      shift_q <= {1'b1, shift_q[NUM_BUTTONS-1:1]};
      if (count_q != 4'(NUM_BUTTONS))
        count_q <= count_q + 4'd1;
    end
  end

  assign o_bit   = shift_q[0];
  assign o_count = count_q;

endmodule

// File: rtl/joypad_bus_responder.sv
// CPU-bus target for the two controller ports at $4016/$4017: strobe latch,
// serial button readout and open-bus merging of the returned byte.
module joypad_bus_responder
  import joypad_pkg::*;
#(
  parameter logic [15:0] ADDR_PORT1  = ADDR_JOY1,
  parameter logic [15:0] ADDR_PORT2  = ADDR_JOY2,
  parameter int          NUM_BUTTONS = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_ce,
  input  logic                   i_rw,
  input  logic [15:0]            i_address,
  input  logic [7:0]             i_data,
  input  logic [7:0]             i_open_bus,
  input  logic [NUM_BUTTONS-1:0] i_buttons1,
  input  logic [NUM_BUTTONS-1:0] i_buttons2,
  output logic [7:0]             o_data,
  output logic                   o_data_en,
  output logic                   o_strobe,
  output logic [3:0]             o_debug_count1,
  output logic [3:0]             o_debug_count2
);

  logic strobe_q;
  logic sel1;
  logic sel2;
  logic strobe_write;
  logic serial1;
  logic serial2;
  logic bit1;
  logic bit2;
  logic unused_data_bits;

  assign sel1         = i_rw && (i_address == ADDR_PORT1);
  assign sel2         = i_rw && (i_address == ADDR_PORT2);
  assign strobe_write = i_ce && !i_rw && (i_address == ADDR_PORT1);
  assign o_data_en    = sel1 | sel2;
  assign o_strobe     = strobe_q;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      strobe_q <= 1'b0;
    else if (strobe_write)
      strobe_q <= i_data[0];
  end

  // Reload keys off the registered strobe, so the 1->0 write cycle still samples.
  joypad_shift_register #(.NUM_BUTTONS(NUM_BUTTONS)) u_pad1 (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (i_ce && strobe_q),
    .i_shift   (i_ce && sel1 && !strobe_q),
    .i_buttons (i_buttons1),
    .o_bit     (serial1),
    .o_count   (o_debug_count1)
  );

  joypad_shift_register #(.NUM_BUTTONS(NUM_BUTTONS)) u_pad2 (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (i_ce && strobe_q),
    .i_shift   (i_ce && sel2 && !strobe_q),
    .i_buttons (i_buttons2),
    .o_bit     (serial2),
    .o_count   (o_debug_count2)
  );

  // While strobing, the pad reports the live A button rather than the latch.
  assign bit1 = strobe_q ? i_buttons1[BTN_A] : serial1;
  assign bit2 = strobe_q ? i_buttons2[BTN_A] : serial2;

  always_comb begin
    o_data = i_open_bus;
    if (sel1)
      o_data = (i_open_bus & OPEN_BUS_MASK) | {7'd0, bit1};
    else if (sel2)
      o_data = (i_open_bus & OPEN_BUS_MASK) | {7'd0, bit2};
  end

  assign unused_data_bits = ^i_data[7:1];

endmodule

// File: tb/tb_joypad_bus_responder.sv
// Self-checking bench for joypad_bus_responder: directed vector table, corner
// sequences and a randomized run against a pad-level behavioural model.
module tb_joypad_bus_responder;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_ce;
  logic        i_rw;
  logic [15:0] i_address;
  logic [7:0]  i_data;
  logic [7:0]  i_open_bus;
  logic [7:0]  i_buttons1;
  logic [7:0]  i_buttons2;
  logic [7:0]  o_data;
  logic        o_data_en;
  logic        o_strobe;
  logic [3:0]  o_debug_count1;
  logic [3:0]  o_debug_count2;

  int errors = 0;
  int checks = 0;

  // Model: strobe flag, the button bytes captured at the last reload and the
  // number of serial reads made since then (reads past 8 return 1).
  logic       m_strobe;
  logic [7:0] m_latch1, m_latch2;
  int         m_idx1, m_idx2;

  logic [7:0] seen_data;
  logic       seen_en;

  joypad_bus_responder dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_ce           (i_ce),
    .i_rw           (i_rw),
    .i_address      (i_address),
    .i_data         (i_data),
    .i_open_bus     (i_open_bus),
    .i_buttons1     (i_buttons1),
    .i_buttons2     (i_buttons2),
    .o_data         (o_data),
    .o_data_en      (o_data_en),
    .o_strobe       (o_strobe),
    .o_debug_count1 (o_debug_count1),
    .o_debug_count2 (o_debug_count2)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic model_bit(input logic [7:0] latch, input int idx);
    return (idx < 8) ? latch[idx] : 1'b1;
  endfunction

  function automatic logic [7:0] model_count(input int idx);
    return (idx < 8) ? 8'(idx) : 8'd8;
  endfunction

  // One CPU bus cycle: drive on the falling edge, check the combinational
  // read data just before the rising edge, then check registered state.
  task automatic applyStimulus(input logic rst, input logic ce, input logic rw,
                               input logic [15:0] addr, input logic [7:0] data,
                               input logic [7:0] ob);
    logic       s1, s2, e_en;
    logic [7:0] e_data;
    @(negedge i_clk);
    i_reset = rst; i_ce = ce; i_rw = rw; i_address = addr; i_data = data; i_open_bus = ob;
    #1;
    s1 = rw && (addr == 16'h4016);
    s2 = rw && (addr == 16'h4017);
    e_en = s1 || s2;
    e_data = ob;
    if (s1) e_data = {ob[7:5], 4'b0000, m_strobe ? i_buttons1[0] : model_bit(m_latch1, m_idx1)};
    else if (s2) e_data = {ob[7:5], 4'b0000, m_strobe ? i_buttons2[0] : model_bit(m_latch2, m_idx2)};
    checkOutput("o_data", o_data, e_data);
    checkOutput("o_data_en", {7'd0, o_data_en}, {7'd0, e_en});
    seen_data = o_data;
    seen_en   = o_data_en;
    @(posedge i_clk);
    if (rst) begin
      m_strobe = 1'b0; m_latch1 = 8'h00; m_latch2 = 8'h00; m_idx1 = 0; m_idx2 = 0;
    end else if (ce) begin
      if (m_strobe) begin
        m_latch1 = i_buttons1; m_latch2 = i_buttons2; m_idx1 = 0; m_idx2 = 0;
      end else begin
        if (s1 && m_idx1 < 8) m_idx1++;
        if (s2 && m_idx2 < 8) m_idx2++;
      end
      if (!rw && addr == 16'h4016) m_strobe = data[0];
    end
    #1;
    checkOutput("o_strobe", {7'd0, o_strobe}, {7'd0, m_strobe});
    checkOutput("count1", {4'd0, o_debug_count1}, model_count(m_idx1));
    checkOutput("count2", {4'd0, o_debug_count2}, model_count(m_idx2));
  endtask

  task automatic strobeSequence();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h4016, 8'h01, 8'h40);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h4016, 8'h00, 8'h40);
  endtask

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  ob;
    logic [7:0]  exp_data;
    logic        exp_en;
    logic [3:0]  exp_cnt1;
  } vec_t;

  vec_t vecs[14];

  initial begin
    i_reset = 1'b1; i_ce = 1'b0; i_rw = 1'b1; i_address = 16'h0000;
    i_data = 8'h00; i_open_bus = 8'h00; i_buttons1 = 8'h00; i_buttons2 = 8'h00;
    m_strobe = 1'b0; m_latch1 = 8'h00; m_latch2 = 8'h00; m_idx1 = 0; m_idx2 = 0;
    repeat (2) @(posedge i_clk);

    // Reset read, strobe sequence with buttons 1000_0101, nine reads, idle read.
    vecs[0]  = '{1'b1, 16'h4016, 8'h00, 8'h40, 8'h40, 1'b1, 4'd1};
    vecs[1]  = '{1'b0, 16'h4016, 8'h01, 8'h40, 8'h40, 1'b0, 4'd1};
    vecs[2]  = '{1'b0, 16'h4016, 8'h00, 8'h40, 8'h40, 1'b0, 4'd0};
    vecs[3]  = '{1'b1, 16'h4016, 8'h00, 8'hFF, 8'hE1, 1'b1, 4'd1};
    vecs[4]  = '{1'b1, 16'h4016, 8'h00, 8'hFF, 8'hE0, 1'b1, 4'd2};
    vecs[5]  = '{1'b1, 16'h4016, 8'h00, 8'hFF, 8'hE1, 1'b1, 4'd3};
    vecs[6]  = '{1'b1, 16'h4016, 8'h00, 8'hFF, 8'hE0, 1'b1, 4'd4};
    vecs[7]  = '{1'b1, 16'h4016, 8'h00, 8'hFF, 8'hE0, 1'b1, 4'd5};
    vecs[8]  = '{1'b1, 16'h4016, 8'h00, 8'h5F, 8'h40, 1'b1, 4'd6};
    vecs[9]  = '{1'b1, 16'h4016, 8'h00, 8'hFF, 8'hE0, 1'b1, 4'd7};
    vecs[10] = '{1'b1, 16'h4016, 8'h00, 8'hFF, 8'hE1, 1'b1, 4'd8};
    vecs[11] = '{1'b1, 16'h4016, 8'h00, 8'hFF, 8'hE1, 1'b1, 4'd8};
    vecs[12] = '{1'b1, 16'h4018, 8'h00, 8'h5A, 8'h5A, 1'b0, 4'd8};
    vecs[13] = '{1'b0, 16'h4017, 8'h01, 8'h33, 8'h33, 1'b0, 4'd8};

    i_buttons1 = 8'b1000_0101;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, 1'b1, vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].ob);
      checkOutput($sformatf("vec%0d_data", i), seen_data, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_en", i), {7'd0, seen_en}, {7'd0, vecs[i].exp_en});
      checkOutput($sformatf("vec%0d_cnt1", i), {4'd0, o_debug_count1}, {4'd0, vecs[i].exp_cnt1});
    end

    // Live A button while strobe is held high.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h4016, 8'h01, 8'h00);
    i_buttons1 = 8'h01;
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h4016, 8'h00, 8'h00);
    checkOutput("live_a_high", seen_data, 8'h01);
    i_buttons1 = 8'h00;
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h4016, 8'h00, 8'h00);
    checkOutput("live_a_low", seen_data, 8'h00);
    checkOutput("live_cnt1", {4'd0, o_debug_count1}, 8'd0);

    // Interleaved port reads.
    i_buttons1 = 8'b1000_0101; i_buttons2 = 8'h02;
    strobeSequence();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h4017, 8'h00, 8'h00);
    checkOutput("p2_bit0", seen_data, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h4016, 8'h00, 8'h00);
    checkOutput("p1_bit0", seen_data, 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h4017, 8'h00, 8'h00);
    checkOutput("p2_bit1", seen_data, 8'h01);
    checkOutput("interleave_cnt1", {4'd0, o_debug_count1}, 8'd1);
    checkOutput("interleave_cnt2", {4'd0, o_debug_count2}, 8'd2);

    // Read held for three clocks, enabled only in the last.
    strobeSequence();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h4016, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h4016, 8'h00, 8'h00);
    checkOutput("held_cnt_pre", {4'd0, o_debug_count1}, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h4016, 8'h00, 8'h00);
    checkOutput("held_cnt1", {4'd0, o_debug_count1}, 8'd1);

    // Reset mid-sequence, then a write to port 2 must not set the strobe.
    i_buttons1 = 8'hFF;
    strobeSequence();
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 16'h4016, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h4016, 8'h01, 8'h00);
    checkOutput("rst_strobe", {7'd0, o_strobe}, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h4016, 8'h00, 8'h00);
    checkOutput("rst_bit0", seen_data, 8'h00);
    checkOutput("rst_cnt1", {4'd0, o_debug_count1}, 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h4017, 8'h01, 8'h00);
    checkOutput("p2_write_strobe", {7'd0, o_strobe}, 8'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] addr;
      i_buttons1 = 8'($urandom);
      i_buttons2 = 8'($urandom);
      case ($urandom_range(0, 3))
        0, 2:    addr = 16'h4016;
        1:       addr = 16'h4017;
        default: addr = 16'($urandom);
      endcase
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0,
                    $urandom_range(0, 2) != 0, addr, 8'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
